// File: rtl/logic_result_fifo_if.sv
// Handshake bundle for the AND/NAND result FIFO: operand input side and result output side.
// The master drives operands and out_ready. The slave (the FIFO) drives results and status.
interface logic_result_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic                       select;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_data;
    logic                       out_sel;
    logic [$clog2(DEPTH):0]     level;
    logic [CNTW-1:0]            delivered;

    modport master (
        output in_valid, a, b, select, out_ready,
        input  in_ready, out_valid, out_data, out_sel, level, delivered
    );

    modport slave (
        input  in_valid, a, b, select, out_ready,
        output in_ready, out_valid, out_data, out_sel, level, delivered
    );
endinterface

// File: rtl/logic_result_fifo.sv
// Registered consumer stage for the AND/NAND gate unit.
// It computes the gate result on push and buffers {select,result} in a show-ahead FIFO.
module logic_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_result_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNTW-1:0]  r_delivered;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_result;

    assign w_and    = bus.a & bus.b;
    assign w_result = bus.select ? ~w_and : w_and;
    assign w_push   = bus.in_valid & (r_state != S_FULL);
    assign w_pop    = bus.out_ready & (r_state != S_EMPTY);

    assign bus.in_ready  = (r_state != S_FULL);
    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.out_data  = r_mem[r_rd_ptr][WIDTH-1:0];
    assign bus.out_sel   = r_mem[r_rd_ptr][WIDTH];
    assign bus.level     = r_level;
    assign bus.delivered = r_delivered;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_PARTIAL;
            S_PARTIAL: begin
                if (w_push && !w_pop && r_level == LW'(DEPTH - 1))
                    w_state_nxt = S_FULL;
                else if (w_pop && !w_push && r_level == LW'(1))
                    w_state_nxt = S_EMPTY;
            end
            S_FULL: if (w_pop) w_state_nxt = S_PARTIAL;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_delivered <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {bus.select, w_result};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PW'(1);
                r_delivered <= r_delivered + CNTW'(1);
            end
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (w_pop && !w_push) r_level <= r_level - LW'(1);
        end
    end
endmodule

// File: tb/tb_logic_result_fifo.sv
// Directed bench for logic_result_fifo: reset, push/pop ordering, full/empty limits,
// backpressure, asynchronous reset mid-cycle and delivered-counter wrap.
module tb_logic_result_fifo;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    logic_result_fifo_if #(.WIDTH(4), .DEPTH(4), .CNTW(8)) bus ();

    logic_result_fifo #(.WIDTH(4), .DEPTH(4), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.select    = 1'b0;
        bus.out_ready = 1'b0;

        // 1: reset
        do_reset();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_level",     32'(bus.level),     32'd0);
        chk("rst_delivered", 32'(bus.delivered), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'd0);

        // 2: single push, AND of C and A
        bus.in_valid = 1'b1; bus.a = 4'hC; bus.b = 4'hA; bus.select = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("p1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("p1_out_data",  32'(bus.out_data),  32'h8);
        chk("p1_out_sel",   32'(bus.out_sel),   32'd0);
        chk("p1_level",     32'(bus.level),     32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("p1_pop_level",     32'(bus.level),     32'd0);
        chk("p1_pop_delivered", 32'(bus.delivered), 32'd1);
        chk("p1_pop_valid",     32'(bus.out_valid), 32'd0);

        // 3: fill and drain
        do_reset();
        bus.a = 4'hF; bus.b = 4'hF; bus.in_valid = 1'b1;
        bus.select = 1'b0; tick();
        bus.select = 1'b1; tick();
        bus.select = 1'b0; tick();
        bus.select = 1'b1; tick();
        chk("full_level",    32'(bus.level),    32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.select = 1'b0; bus.a = 4'h0;
        tick();
        bus.in_valid = 1'b0;
        chk("full_hold_level", 32'(bus.level),    32'd4);
        chk("full_hold_data",  32'(bus.out_data), 32'hF);
        bus.out_ready = 1'b1;
        chk("drain0_data", 32'(bus.out_data), 32'hF); chk("drain0_sel", 32'(bus.out_sel), 32'd0); tick();
        chk("drain1_data", 32'(bus.out_data), 32'h0); chk("drain1_sel", 32'(bus.out_sel), 32'd1); tick();
        chk("drain2_data", 32'(bus.out_data), 32'hF); chk("drain2_sel", 32'(bus.out_sel), 32'd0); tick();
        chk("drain3_data", 32'(bus.out_data), 32'h0); chk("drain3_sel", 32'(bus.out_sel), 32'd1); tick();
        bus.out_ready = 1'b0;
        chk("drain_delivered", 32'(bus.delivered), 32'd4);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_level",     32'(bus.level),     32'd0);
        chk("drain_in_ready",  32'(bus.in_ready),  32'd1);

        // 4: push+pop at level 2
        bus.in_valid = 1'b1; bus.a = 4'hC; bus.b = 4'hA;
        bus.select = 1'b0; tick();
        bus.select = 1'b1; tick();
        chk("pp_pre_level", 32'(bus.level), 32'd2);
        bus.a = 4'h0; bus.b = 4'h0; bus.select = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("pp_level",     32'(bus.level),     32'd2);
        chk("pp_delivered", 32'(bus.delivered), 32'd5);
        chk("pp_head_data", 32'(bus.out_data),  32'h7);
        chk("pp_head_sel",  32'(bus.out_sel),   32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("pp_tail_data", 32'(bus.out_data), 32'hF);
        chk("pp_tail_sel",  32'(bus.out_sel),  32'd1);
        tick();
        bus.out_ready = 1'b0;
        chk("pp_empty_level", 32'(bus.level), 32'd0);

        // 5: backpressure
        bus.in_valid = 1'b1; bus.a = 4'h6; bus.b = 4'h3; bus.select = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data",      32'(bus.out_data),  32'h2);
            chk("bp_sel",       32'(bus.out_sel),   32'd0);
            chk("bp_delivered", 32'(bus.delivered), 32'd7);
            tick();
        end
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_pop_delivered", 32'(bus.delivered), 32'd8);

        // 6: async reset mid-cycle at level 3, then counter wrap
        bus.in_valid = 1'b1; bus.a = 4'hF; bus.b = 4'hF; bus.select = 1'b0;
        tick(); tick(); tick();
        bus.in_valid = 1'b0;
        chk("ar_pre_level", 32'(bus.level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_level",     32'(bus.level),     32'd0);
        chk("ar_delivered", 32'(bus.delivered), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        repeat (255) tick();
        chk("wrap_255", 32'(bus.delivered), 32'd255);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("wrap_0",     32'(bus.delivered), 32'd0);
        chk("wrap_level", 32'(bus.level),     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
